id_ex_stage: RTL and testbench

Pipeline register between decode and execute, with the execute-side operand forwarding muxes and load-use detection. It captures decoded operands and control each cycle. It resolves RAW hazards by selecting ALU operands from the register file, the EX/MEM result, or the MEM/WB result. It drives the ALU's `src1`, `src2` and `control` inputs directly.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage_forward_unit.sv | 30 +++
 rtl/id_ex_stage.sv | 108 ++++++++++
 tb/tb_id_ex_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared ALU op, forwarding select and ID/EX control types
package pipeline_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        SLT = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic valid;
        logic alu_src;
        logic reg_dst;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic branch;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs, forwarding sources and execute-side outputs
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
);
    logic             stall;
    logic             flush;
    logic             id_valid;
    logic [WIDTH-1:0] id_rd1;
    logic [WIDTH-1:0] id_rd2;
    logic [WIDTH-1:0] id_imm;
    logic [RADDR-1:0] id_rs;
    logic [RADDR-1:0] id_rt;
    logic [RADDR-1:0] id_rd;
    logic [2:0]       id_alu_control;
    logic             id_alu_src;
    logic             id_reg_dst;
    logic             id_reg_write;
    logic             id_mem_to_reg;
    logic             id_mem_write;
    logic             id_branch;
    logic             mem_reg_write;
    logic [RADDR-1:0] mem_write_reg;
    logic [WIDTH-1:0] mem_alu_result;
    logic             wb_reg_write;
    logic [RADDR-1:0] wb_write_reg;
    logic [WIDTH-1:0] wb_result;
    logic [WIDTH-1:0] ex_src1;
    logic [WIDTH-1:0] ex_src2;
    logic [2:0]       ex_alu_control;
    logic [WIDTH-1:0] ex_store_data;
    logic [RADDR-1:0] ex_write_reg;
    logic             ex_reg_write;
    logic             ex_mem_to_reg;
    logic             ex_mem_write;
    logic             ex_branch;
    logic             ex_valid;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             load_use;

    modport master (
        output stall, flush, id_valid, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
               id_alu_control, id_alu_src, id_reg_dst, id_reg_write, id_mem_to_reg,
               id_mem_write, id_branch, mem_reg_write, mem_write_reg, mem_alu_result,
               wb_reg_write, wb_write_reg, wb_result,
        input  ex_src1, ex_src2, ex_alu_control, ex_store_data, ex_write_reg,
               ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch, ex_valid,
               fwd_a, fwd_b, load_use
    );

    modport slave (
        input  stall, flush, id_valid, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
               id_alu_control, id_alu_src, id_reg_dst, id_reg_write, id_mem_to_reg,
               id_mem_write, id_branch, mem_reg_write, mem_write_reg, mem_alu_result,
               wb_reg_write, wb_write_reg, wb_result,
        output ex_src1, ex_src2, ex_alu_control, ex_store_data, ex_write_reg,
               ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch, ex_valid,
               fwd_a, fwd_b, load_use
    );
endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// rtl/id_ex_stage_forward_unit.sv - combinational RAW forwarding select for rs and rt
module forward_unit
    import pipeline_pkg::*;
#(
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] i_rs,
    input  logic [RADDR-1:0] i_rt,
    input  logic             i_mem_reg_write,
    input  logic [RADDR-1:0] i_mem_write_reg,
    input  logic             i_wb_reg_write,
    input  logic [RADDR-1:0] i_wb_write_reg,
    output fwd_sel_t         o_fwd_a,
    output fwd_sel_t         o_fwd_b
);

    // The younger EX/MEM result shadows MEM/WB; r0 is hard-wired and never forwarded.
    function automatic fwd_sel_t pick(input logic [RADDR-1:0] src);
        if (i_mem_reg_write && (i_mem_write_reg != '0) && (i_mem_write_reg == src))
            return FWD_MEM;
        else if (i_wb_reg_write && (i_wb_write_reg != '0) && (i_wb_write_reg == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    assign o_fwd_a = pick(i_rs);
    assign o_fwd_b = pick(i_rt);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    id_ex_stage_if.slave  bus
);

    id_ex_ctrl_t      r_ctrl;
    alu_op_t          r_alu_control;
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] r_imm;
    logic [RADDR-1:0] r_rs;
    logic [RADDR-1:0] r_rt;
    logic [RADDR-1:0] r_rd;

    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;
    logic [WIDTH-1:0] w_src1;
    logic [WIDTH-1:0] w_store_data;
    logic             w_load_use;

    assign w_load_use = r_ctrl.valid && r_ctrl.mem_to_reg && bus.id_valid &&
                        ((r_rt == bus.id_rs) || (r_rt == bus.id_rt)) && (r_rt != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl        <= '0;
            r_alu_control <= ADD;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_imm         <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
        end else if (bus.flush || (!bus.stall && w_load_use)) begin
            r_ctrl        <= '0;
            r_alu_control <= ADD;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_imm         <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
        end else if (!bus.stall) begin
            r_ctrl.valid      <= bus.id_valid;
            r_ctrl.alu_src    <= bus.id_alu_src;
            r_ctrl.reg_dst    <= bus.id_reg_dst;
            r_ctrl.reg_write  <= bus.id_reg_write;
            r_ctrl.mem_to_reg <= bus.id_mem_to_reg;
            r_ctrl.mem_write  <= bus.id_mem_write;
            r_ctrl.branch     <= bus.id_branch;
            r_alu_control     <= alu_op_t'(bus.id_alu_control);
            r_rd1             <= bus.id_rd1;
            r_rd2             <= bus.id_rd2;
            r_imm             <= bus.id_imm;
            r_rs              <= bus.id_rs;
            r_rt              <= bus.id_rt;
            r_rd              <= bus.id_rd;
        end
    end

    forward_unit #(.RADDR(RADDR)) u_forward_unit (
        .i_rs            (r_rs),
        .i_rt            (r_rt),
        .i_mem_reg_write (bus.mem_reg_write),
        .i_mem_write_reg (bus.mem_write_reg),
        .i_wb_reg_write  (bus.wb_reg_write),
        .i_wb_write_reg  (bus.wb_write_reg),
        .o_fwd_a         (w_fwd_a),
        .o_fwd_b         (w_fwd_b)
    );

    always_comb begin
        w_src1       = r_rd1;
        w_store_data = r_rd2;
        case (w_fwd_a)
            FWD_MEM: w_src1 = bus.mem_alu_result;
            FWD_WB:  w_src1 = bus.wb_result;
            default: w_src1 = r_rd1;
        endcase
        case (w_fwd_b)
            FWD_MEM: w_store_data = bus.mem_alu_result;
            FWD_WB:  w_store_data = bus.wb_result;
            default: w_store_data = r_rd2;
        endcase
    end

    assign bus.ex_src1        = w_src1;
    assign bus.ex_store_data  = w_store_data;
    assign bus.ex_src2        = r_ctrl.alu_src ? r_imm : w_store_data;
    assign bus.ex_alu_control = r_alu_control;
    assign bus.ex_write_reg   = r_ctrl.reg_dst ? r_rd : r_rt;
    assign bus.ex_reg_write   = r_ctrl.reg_write;
    assign bus.ex_mem_to_reg  = r_ctrl.mem_to_reg;
    assign bus.ex_mem_write   = r_ctrl.mem_write;
    assign bus.ex_branch      = r_ctrl.branch;
    assign bus.ex_valid       = r_ctrl.valid;
    assign bus.fwd_a          = w_fwd_a;
    assign bus.fwd_b          = w_fwd_b;
    assign bus.load_use       = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_asserts = 0;
    int   n_fail    = 0;

    id_ex_stage_if #(.WIDTH(32), .RADDR(5)) bus ();

    id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic valid, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [2:0] alu, input logic alu_src,
                          input logic reg_dst, input logic reg_write, input logic mem_to_reg,
                          input logic mem_write, input logic branch);
        bus.id_valid       = valid;
        bus.id_rd1         = rd1;
        bus.id_rd2         = rd2;
        bus.id_imm         = imm;
        bus.id_rs          = rs;
        bus.id_rt          = rt;
        bus.id_rd          = rd;
        bus.id_alu_control = alu;
        bus.id_alu_src     = alu_src;
        bus.id_reg_dst     = reg_dst;
        bus.id_reg_write   = reg_write;
        bus.id_mem_to_reg  = mem_to_reg;
        bus.id_mem_write   = mem_write;
        bus.id_branch      = branch;
    endtask

    task automatic clear_fwd();
        bus.mem_reg_write  = 1'b0;
        bus.mem_write_reg  = '0;
        bus.mem_alu_result = '0;
        bus.wb_reg_write   = 1'b0;
        bus.wb_write_reg   = '0;
        bus.wb_result      = '0;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clear_fwd();
        set_id(1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'b000, 0, 1, 1, 0, 0, 0);

        // reset holds everything at zero despite live id_* inputs
        step();
        step();
        chk("rst_valid", bus.ex_valid, 0);
        chk("rst_src1", bus.ex_src1, 0);
        chk("rst_src2", bus.ex_src2, 0);
        chk("rst_store", bus.ex_store_data, 0);
        chk("rst_fwd", {bus.fwd_a, bus.fwd_b}, 0);
        chk("rst_load_use", bus.load_use, 0);

        reset_n = 1'b1;
        step();
        chk("cap_src1", bus.ex_src1, 5);
        chk("cap_src2", bus.ex_src2, 7);
        chk("cap_fwd", {bus.fwd_a, bus.fwd_b}, 0);
        chk("cap_valid", bus.ex_valid, 1);
        chk("cap_wreg", bus.ex_write_reg, 3);
        chk("cap_regwr", bus.ex_reg_write, 1);

        // asynchronous mid-stream reset
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", bus.ex_valid, 0);
        chk("mrst_src1", bus.ex_src1, 0);
        step();
        chk("mrst_hold", bus.ex_reg_write, 0);
        reset_n = 1'b1;
        step();
        chk("mrst_recap", bus.ex_src1, 5);

        // double hazard: EX/MEM wins, then MEM/WB alone
        set_id(1, 32'h111, 32'h222, 32'd0, 5'd3, 5'd5, 5'd6, 3'b001, 0, 1, 1, 0, 0, 0);
        step();
        bus.mem_reg_write = 1; bus.mem_write_reg = 5'd3; bus.mem_alu_result = 32'h10;
        bus.wb_reg_write  = 1; bus.wb_write_reg  = 5'd3; bus.wb_result      = 32'h20;
        #1;
        chk("dh_fwd_a", bus.fwd_a, 2'b10);
        chk("dh_src1", bus.ex_src1, 32'h10);
        chk("dh_fwd_b", bus.fwd_b, 2'b00);
        chk("dh_store", bus.ex_store_data, 32'h222);
        bus.mem_reg_write = 0;
        bus.wb_write_reg  = 5'd5;
        #1;
        chk("wb_fwd_a", bus.fwd_a, 2'b00);
        chk("wb_fwd_b", bus.fwd_b, 2'b01);
        chk("wb_src2", bus.ex_src2, 32'h20);
        bus.wb_write_reg  = 5'd3;
        #1;
        chk("wb_src1", bus.ex_src1, 32'h20);
        clear_fwd();

        // register zero never forwarded
        set_id(1, 32'h1, 32'h333, 32'd0, 5'd6, 5'd0, 5'd8, 3'b010, 0, 1, 1, 0, 0, 0);
        step();
        bus.mem_reg_write = 1; bus.mem_write_reg = 5'd0; bus.mem_alu_result = 32'hDEAD;
        bus.wb_reg_write  = 1; bus.wb_write_reg  = 5'd0; bus.wb_result      = 32'hBEEF;
        #1;
        chk("r0_fwd_b", bus.fwd_b, 2'b00);
        chk("r0_store", bus.ex_store_data, 32'h333);
        clear_fwd();

        // load-use: detect, hold under stall, bubble, then WB forwarding
        set_id(1, 32'h0, 32'h0, 32'd8, 5'd1, 5'd4, 5'd0, 3'b000, 1, 0, 1, 1, 0, 0);
        step();
        set_id(1, 32'h40, 32'h41, 32'd0, 5'd4, 5'd7, 5'd9, 3'b000, 0, 1, 1, 0, 0, 0);
        #1;
        chk("lu_detect", bus.load_use, 1);
        chk("lu_wreg", bus.ex_write_reg, 4);
        chk("lu_src2_imm", bus.ex_src2, 8);
        bus.stall = 1;
        step();
        chk("lu_stall_valid", bus.ex_valid, 1);
        chk("lu_stall_m2r", bus.ex_mem_to_reg, 1);
        chk("lu_stall_req", bus.load_use, 1);
        bus.stall = 0;
        step();
        chk("lu_bub_valid", bus.ex_valid, 0);
        chk("lu_bub_ctrl", {bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_branch}, 0);
        chk("lu_bub_clear", bus.load_use, 0);
        bus.wb_reg_write = 1; bus.wb_write_reg = 5'd4; bus.wb_result = 32'h99;
        step();
        chk("lu_fwd_a", bus.fwd_a, 2'b01);
        chk("lu_src1", bus.ex_src1, 32'h99);
        chk("lu_valid", bus.ex_valid, 1);
        chk("lu_wreg2", bus.ex_write_reg, 9);
        chk("lu_store", bus.ex_store_data, 32'h41);
        clear_fwd();

        // flush wins over stall
        bus.flush = 1; bus.stall = 1;
        step();
        chk("fs_valid", bus.ex_valid, 0);
        chk("fs_regwr", bus.ex_reg_write, 0);
        chk("fs_alu", bus.ex_alu_control, 0);
        chk("fs_store", bus.ex_store_data, 0);
        bus.flush = 0; bus.stall = 0;

        set_id(1, 32'hA, 32'hB, 32'd0, 5'd10, 5'd11, 5'd12, 3'b001, 0, 1, 1, 0, 0, 1);
        step();
        chk("x_branch", bus.ex_branch, 1);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h100 + i, 32'h200 + i, 32'h300 + i, 5'(20 + i), 5'(24 + i),
                   5'(28 + i), 3'b011, 1, 0, 0, 1, 1, 0);
            step();
            chk("st_src1", bus.ex_src1, 32'hA);
            chk("st_store", bus.ex_store_data, 32'hB);
            chk("st_alu", bus.ex_alu_control, 3'b001);
            chk("st_wreg", bus.ex_write_reg, 12);
            chk("st_ctrl", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_branch}, 5'b11001);
        end
        bus.stall = 0;
        bus.flush = 1;
        step();
        chk("fl_valid", bus.ex_valid, 0);
        chk("fl_branch", bus.ex_branch, 0);
        bus.flush = 0;

        // immediate operand with rt still forwarded to store data
        set_id(1, 32'h3, 32'h55, 32'hFFFF_FFFC, 5'd1, 5'd13, 5'd14, 3'b101, 1, 1, 1, 0, 0, 0);
        step();
        chk("im_src2", bus.ex_src2, 32'hFFFF_FFFC);
        chk("im_alu", bus.ex_alu_control, 3'b101);
        chk("im_store", bus.ex_store_data, 32'h55);
        chk("im_src1", bus.ex_src1, 32'h3);
        bus.mem_reg_write = 1; bus.mem_write_reg = 5'd13; bus.mem_alu_result = 32'h77;
        #1;
        chk("im_fwd_b", bus.fwd_b, 2'b10);
        chk("im_store_fwd", bus.ex_store_data, 32'h77);
        chk("im_src2_keep", bus.ex_src2, 32'hFFFF_FFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
